// File: rtl/recv_nibble_deframer_pkg.sv
// Shared definitions for the nibble deframer and the transmit-side control-block decoder.
package recv_nibble_deframer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA_LO,
        DATA_HI,
        DONE,
        DROP
    } state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    localparam int unsigned ERR_RUNT  = 0;
    localparam int unsigned ERR_LONG  = 1;
    localparam int unsigned ERR_ALIGN = 2;
    localparam int unsigned ERR_NOPRE = 3;

    localparam int unsigned LEN_MSB  = 23;
    localparam int unsigned LEN_LSB  = 12;
    localparam int unsigned FLAG_MSB = 3;

    function automatic logic [23:0] pack_ctrl(input logic [11:0] len, input logic [3:0] flags);
        logic [23:0] ctrl;
        ctrl = '0;
        ctrl[LEN_MSB:LEN_LSB] = len;
        ctrl[FLAG_MSB:0]      = flags;
        return ctrl;
    endfunction

endpackage

// File: rtl/recv_nibble_deframer_len_checker.sv
// Per-frame byte counter: saturating count, MAX_LEN acceptance gate, RUNT/LONG flags.
module recv_len_checker #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1536
) (
    input  logic        clk_phy,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_in,
    output logic [11:0] byte_cnt,
    output logic        accept,
    output logic        long_flag,
    output logic        runt_flag
);

    localparam logic [11:0] MAX_W = 12'(MAX_LEN);
    localparam logic [11:0] MIN_W = 12'(MIN_LEN);

    always_comb begin
        accept    = byte_cnt < MAX_W;
        runt_flag = byte_cnt < MIN_W;
    end

    // Bytes beyond MAX_LEN are neither counted nor emitted; they only raise LONG.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            byte_cnt  <= '0;
            long_flag <= 1'b0;
        end else if (clear) begin
            byte_cnt  <= '0;
            long_flag <= 1'b0;
        end else if (byte_in) begin
            if (accept && byte_cnt != '1)
                byte_cnt <= byte_cnt + 12'd1;
            if (!accept)
                long_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/recv_nibble_deframer.sv
// MII receive deframer: strips preamble/SFD, rebuilds bytes low nibble first, reports frame status.
module recv_nibble_deframer
    import recv_nibble_deframer_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1536,
    parameter int unsigned PRE_MIN = 4
) (
    input  logic        clk_phy,
    input  logic        reset,
    input  logic [3:0]  phy_data_in,
    input  logic        phy_rx_dv,
    output logic [7:0]  f_data_out,
    output logic        f_data_valid,
    output logic [23:0] f_ctrl_out,
    output logic        f_frame_valid,
    output logic [3:0]  rx_err_flags
);

    localparam logic [3:0] PRE_MIN_W = 4'(PRE_MIN);

    state_t      state;
    logic [3:0]  pre_cnt;
    logic [3:0]  low_nib;
    logic        nopre;
    logic        clear;
    logic        byte_in;
    logic [11:0] byte_cnt;
    logic        accept;
    logic        long_flag;
    logic        runt_flag;
    logic [3:0]  frame_flags;

    always_comb begin
        clear   = (state != DATA_LO) && (state != DATA_HI);
        byte_in = (state == DATA_HI) && phy_rx_dv;
        frame_flags            = '0;
        frame_flags[ERR_RUNT]  = runt_flag;
        frame_flags[ERR_LONG]  = long_flag;
        frame_flags[ERR_ALIGN] = (state == DATA_HI);
        frame_flags[ERR_NOPRE] = nopre;
    end

    recv_len_checker #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_len_checker (
        .clk_phy   (clk_phy),
        .reset     (reset),
        .clear     (clear),
        .byte_in   (byte_in),
        .byte_cnt  (byte_cnt),
        .accept    (accept),
        .long_flag (long_flag),
        .runt_flag (runt_flag)
    );

    // The frame report is registered on the edge that sees dv fall, so it is visible
    // during the DONE cycle, which itself accepts the next preamble.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pre_cnt       <= '0;
            low_nib       <= '0;
            nopre         <= 1'b0;
            f_data_out    <= '0;
            f_data_valid  <= 1'b0;
            f_ctrl_out    <= '0;
            f_frame_valid <= 1'b0;
            rx_err_flags  <= '0;
        end else begin
            f_data_valid  <= 1'b0;
            f_frame_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    nopre <= 1'b0;
                    if (!phy_rx_dv) begin
                        state <= IDLE;
                    end else if (phy_data_in == PREAMBLE_NIB) begin
                        state   <= PREAMBLE;
                        pre_cnt <= 4'd1;
                    end else begin
                        state <= DROP;
                    end
                end
                PREAMBLE: begin
                    if (!phy_rx_dv) begin
                        state <= IDLE;
                    end else if (phy_data_in == PREAMBLE_NIB) begin
                        if (pre_cnt != '1)
                            pre_cnt <= pre_cnt + 4'd1;
                    end else if (phy_data_in == SFD_NIB) begin
                        state <= DATA_LO;
                        nopre <= pre_cnt < PRE_MIN_W;
                    end else begin
                        state <= DROP;
                    end
                end
                DATA_LO, DATA_HI: begin
                    if (!phy_rx_dv) begin
                        state         <= DONE;
                        f_ctrl_out    <= pack_ctrl(byte_cnt, frame_flags);
                        f_frame_valid <= 1'b1;
                        rx_err_flags  <= rx_err_flags | frame_flags;
                    end else if (state == DATA_LO) begin
                        low_nib <= phy_data_in;
                        state   <= DATA_HI;
                    end else begin
                        if (accept) begin
                            f_data_out   <= {phy_data_in, low_nib};
                            f_data_valid <= 1'b1;
                        end
                        state <= DATA_LO;
                    end
                end
                DROP: begin
                    if (!phy_rx_dv)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recv_nibble_deframer.sv
// Directed, table-driven bench for recv_nibble_deframer with hand-computed expectations.
module tb_recv_nibble_deframer;

    logic        clk_phy = 1'b0;
    logic        reset;
    logic [3:0]  phy_data_in;
    logic        phy_rx_dv;
    logic [7:0]  f_data_out;
    logic        f_data_valid;
    logic [23:0] f_ctrl_out;
    logic        f_frame_valid;
    logic [3:0]  rx_err_flags;

    int checks   = 0;
    int failures = 0;

    int          strobe_cnt = 0;
    int          bad_data   = 0;
    int          fv_cnt     = 0;
    int          overlap    = 0;
    logic [7:0]  exp_byte   = 8'h00;
    logic [23:0] last_ctrl  = '0;
    logic [23:0] prev_ctrl  = '0;

    always #5 clk_phy = ~clk_phy;

    recv_nibble_deframer #(
        .MIN_LEN (64),
        .MAX_LEN (1536),
        .PRE_MIN (4)
    ) dut (
        .clk_phy       (clk_phy),
        .reset         (reset),
        .phy_data_in   (phy_data_in),
        .phy_rx_dv     (phy_rx_dv),
        .f_data_out    (f_data_out),
        .f_data_valid  (f_data_valid),
        .f_ctrl_out    (f_ctrl_out),
        .f_frame_valid (f_frame_valid),
        .rx_err_flags  (rx_err_flags)
    );

    always @(negedge clk_phy) begin
        if (f_data_valid) begin
            strobe_cnt++;
            if (f_data_out !== exp_byte) bad_data++;
        end
        if (f_frame_valid) begin
            fv_cnt++;
            prev_ctrl = last_ctrl;
            last_ctrl = f_ctrl_out;
        end
        if (f_data_valid && f_frame_valid) overlap++;
    end

    typedef struct {
        int unsigned pre;
        bit          sfd;
        int unsigned nbytes;
        logic [7:0]  b;
        bit          extra;
        int unsigned exp_strb;
        bit          exp_fv;
        logic [23:0] exp_ctrl;
        logic [3:0]  exp_sticky;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [3:0] nib);
        @(posedge clk_phy);
        #1;
        phy_rx_dv   = dv;
        phy_data_in = nib;
    endtask

    task automatic send_frame(input int unsigned pre, input bit sfd, input int unsigned nbytes,
                              input logic [7:0] b, input bit extra);
        for (int unsigned i = 0; i < pre; i++) drive(1'b1, 4'h5);
        if (sfd) begin
            drive(1'b1, 4'hD);
            for (int unsigned i = 0; i < nbytes; i++) begin
                drive(1'b1, b[3:0]);
                drive(1'b1, b[7:4]);
            end
            if (extra) drive(1'b1, 4'h7);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, 4'h0);
    endtask

    int s0, d0, f0, o0;

    initial begin
        //            pre sfd nbytes  b     ext strb  fv  ctrl          sticky
        vecs[0] = '{7,  1, 128,  8'hAA, 0, 128,  1, 24'h080000, 4'h0};
        vecs[1] = '{18, 1, 1536, 8'h96, 0, 1536, 1, 24'h600000, 4'h0};
        vecs[2] = '{7,  1, 32,   8'hCC, 0, 32,   1, 24'h020001, 4'h1};
        vecs[3] = '{7,  1, 1600, 8'h11, 0, 1536, 1, 24'h600002, 4'h3};
        vecs[4] = '{7,  1, 100,  8'hEE, 1, 100,  1, 24'h064004, 4'h7};
        vecs[5] = '{2,  1, 64,   8'h5A, 0, 64,   1, 24'h040008, 4'hF};
        vecs[6] = '{8,  0, 0,    8'h00, 0, 0,    0, 24'h000000, 4'hF};
        vecs[7] = '{4,  1, 0,    8'h00, 0, 0,    1, 24'h000001, 4'hF};
        vecs[8] = '{3,  1, 63,   8'h3C, 0, 63,   1, 24'h03F009, 4'hF};

        reset       = 1'b0;
        phy_rx_dv   = 1'b0;
        phy_data_in = 4'h0;
        repeat (3) @(negedge clk_phy);
        check("rst_data",   {24'h0, f_data_out}, 32'h0);
        check("rst_dvalid", {31'h0, f_data_valid}, 32'h0);
        check("rst_ctrl",   {8'h0, f_ctrl_out}, 32'h0);
        check("rst_fvalid", {31'h0, f_frame_valid}, 32'h0);
        check("rst_sticky", {28'h0, rx_err_flags}, 32'h0);
        @(posedge clk_phy);
        #1 reset = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            s0 = strobe_cnt; d0 = bad_data; f0 = fv_cnt; o0 = overlap;
            exp_byte = vecs[i].b;
            send_frame(vecs[i].pre, vecs[i].sfd, vecs[i].nbytes, vecs[i].b, vecs[i].extra);
            drive(1'b0, 4'h0);
            @(negedge clk_phy);
            check($sformatf("v%0d_fv_early", i), {31'h0, f_frame_valid}, 32'h0);
            @(negedge clk_phy);
            check($sformatf("v%0d_fv_latency", i), {31'h0, f_frame_valid}, {31'h0, vecs[i].exp_fv});
            idle(3);
            check($sformatf("v%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strb);
            check($sformatf("v%0d_data", i), bad_data - d0, 0);
            check($sformatf("v%0d_fv_count", i), fv_cnt - f0, {31'h0, vecs[i].exp_fv});
            check($sformatf("v%0d_overlap", i), overlap - o0, 0);
            if (vecs[i].exp_fv)
                check($sformatf("v%0d_ctrl", i), {8'h0, f_ctrl_out}, {8'h0, vecs[i].exp_ctrl});
            check($sformatf("v%0d_sticky", i), {28'h0, rx_err_flags}, {28'h0, vecs[i].exp_sticky});
        end

        // Bad first nibble: whole burst dropped even though a preamble/SFD follows.
        s0 = strobe_cnt; f0 = fv_cnt;
        drive(1'b1, 4'h3);
        send_frame(7, 1, 10, 8'h42, 0);
        idle(4);
        check("drop_strobes", strobe_cnt - s0, 0);
        check("drop_fv", fv_cnt - f0, 0);

        // Back-to-back frames separated by a single dv-low cycle.
        s0 = strobe_cnt; d0 = bad_data; f0 = fv_cnt;
        exp_byte = 8'h69;
        send_frame(7, 1, 64, 8'h69, 0);
        drive(1'b0, 4'h0);
        send_frame(7, 1, 64, 8'h69, 0);
        idle(4);
        check("b2b_fv_count", fv_cnt - f0, 2);
        check("b2b_ctrl1", {8'h0, prev_ctrl}, 32'h040000);
        check("b2b_ctrl2", {8'h0, last_ctrl}, 32'h040000);
        check("b2b_strobes", strobe_cnt - s0, 128);
        check("b2b_data", bad_data - d0, 0);

        // Asynchronous reset in the middle of a frame.
        exp_byte = 8'h3C;
        send_frame(7, 1, 10, 8'h3C, 0);
        @(posedge clk_phy);
        #3;
        reset     = 1'b0;
        phy_rx_dv = 1'b0;
        #1;
        check("mid_rst_data",   {24'h0, f_data_out}, 32'h0);
        check("mid_rst_dvalid", {31'h0, f_data_valid}, 32'h0);
        check("mid_rst_ctrl",   {8'h0, f_ctrl_out}, 32'h0);
        check("mid_rst_fvalid", {31'h0, f_frame_valid}, 32'h0);
        check("mid_rst_sticky", {28'h0, rx_err_flags}, 32'h0);
        idle(2);
        #1 reset = 1'b1;
        idle(2);

        s0 = strobe_cnt; d0 = bad_data; f0 = fv_cnt;
        exp_byte = 8'hA5;
        send_frame(7, 1, 64, 8'hA5, 0);
        idle(4);
        check("post_rst_strobes", strobe_cnt - s0, 64);
        check("post_rst_data", bad_data - d0, 0);
        check("post_rst_fv", fv_cnt - f0, 1);
        check("post_rst_ctrl", {8'h0, f_ctrl_out}, 32'h040000);
        check("post_rst_sticky", {28'h0, rx_err_flags}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recv_nibble_deframer.md
Name: recv_nibble_deframer

Overview:
- PHY-side receiver; mirror of the transmit path's nibble serializer.
- Accepts 4-bit MII-style nibbles with a data-valid strobe on clk_phy, strips preamble/SFD, and reassembles bytes low-nibble-first.
- Emits a per-byte data stream and, at end of frame, a 24-bit control block with a frame-valid pulse, in the same format the transmit front end consumes.
- Sits between the PHY pins and the receive-side buffering logic.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (after SFD).
- MAX_LEN, 1536, maximum legal frame length in bytes; must be ≤ 4095.
- PRE_MIN, 4, minimum count of 0x5 preamble nibbles required before SFD.

Ports:
- clk_phy  in  1  PHY clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- phy_data_in  in  4  received nibble.
- phy_rx_dv  in  1  nibble-valid / carrier strobe.
- f_data_out  out  8  reassembled byte.
- f_data_valid  out  1  one-cycle strobe per byte.
- f_ctrl_out  out  24  control block: [23:12] byte count; [11:4] zero; [3:0] error flags.
- f_frame_valid  out  1  one-cycle strobe qualifying f_ctrl_out.
- rx_err_flags  out  4  sticky OR of all error flags since reset.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, counters 0.
- Error flag bits:
  - [0] RUNT: byte count < MIN_LEN.
  - [1] LONG: more than MAX_LEN bytes received.
  - [2] ALIGN: odd nibble count at end of frame.
  - [3] NOPRE: fewer than PRE_MIN preamble nibbles before the SFD.
- States: IDLE, PREAMBLE, DATA_LO, DATA_HI, DONE, DROP.
- IDLE:
  - phy_rx_dv=1 with nibble 0x5 → PREAMBLE, pre_cnt=1.
  - phy_rx_dv=1 with any other nibble → DROP.
- PREAMBLE:
  - 0x5 → pre_cnt++ (saturates at 15).
  - 0xD → DATA_LO; set NOPRE if pre_cnt < PRE_MIN.
  - Other nibble → DROP.
  - phy_rx_dv=0 → IDLE. No frame_valid is emitted.
- DATA_LO: latch nibble into low half → DATA_HI. phy_rx_dv=0 here → DONE with ALIGN=0.
- DATA_HI:
  - Byte = {nibble, low}. f_data_out and f_data_valid register one cycle after the high nibble is sampled.
  - byte_cnt++ (12-bit, saturates at 4095). Return to DATA_LO.
  - phy_rx_dv=0 here → DONE with ALIGN=1. The partial byte is discarded.
- LONG: once byte_cnt = MAX_LEN, further bytes are not emitted and LONG is set. Nibbles are still consumed until phy_rx_dv falls.
- DONE (one cycle):
  - f_ctrl_out = {byte_cnt, 8'h00, flags}, f_frame_valid=1.
  - RUNT evaluated here.
  - byte_cnt and flags clear; → IDLE.
- DROP: ignore input until phy_rx_dv=0 → IDLE. No outputs.
- End-of-frame latency: f_frame_valid asserts exactly one cycle after the first cycle with phy_rx_dv=0.
- f_data_valid and f_frame_valid are never asserted in the same cycle. The last byte strobe precedes frame_valid by ≥1 cycle.
- Back-to-back frames: a new preamble may begin in the DONE cycle. DONE must go straight to PREAMBLE if phy_rx_dv=1 with 0x5.
- f_data_out and f_ctrl_out hold their last values between strobes.
- rx_err_flags is cleared only by reset.

Decomposition:
- Shared package:
  - state enum.
  - Constants PREAMBLE_NIB=4'h5, SFD_NIB=4'hD.
  - Error-bit index constants.
  - Ctrl-block field offsets (LEN_MSB=23, LEN_LSB=12).
  - These are reused by the transmit-side ctrl decoder.
- One natural sub-module, recv_len_checker: byte counter with saturation, MAX_LEN gate, and RUNT/LONG flag generation.

Test Plan:
- Nominal frame: 7×0x5, 0xD, then 128 bytes 0xAA sent as nibbles A,A → 128 f_data_valid pulses with 0xAA; f_ctrl_out=24'h080000; f_frame_valid one cycle after dv drop.
- Runt frame: preamble+SFD, then 32 bytes 0xCC → f_ctrl_out=24'h020001; rx_err_flags[0]=1.
- Oversize frame: 1600 bytes 0x11 → exactly 1536 byte strobes; f_ctrl_out=24'h600002.
- Odd nibble: 100 bytes 0xEE plus one extra nibble → 100 strobes; f_ctrl_out=24'h064004.
- Short preamble / no SFD: 2×0x5 then SFD then 64 bytes → flags=4'h8 and length 0x040. Separately, 8×0x5 then dv drop → no strobes at all.
- Back-to-back frames and mid-frame reset:
  - Two 64-byte frames with a 1-cycle dv gap → two frame_valid pulses, each with length 0x040.
  - reset=0 asserted mid-frame → all outputs 0 immediately.
  - Next full frame after reset is received correctly.
